// File: rtl/nibble_serial_adder_ctrl_if.sv
// Bundle of the operand/result handshakes and the 4-bit adder-stage
// connections of the nibble-serial adder sequencer.
// The controller uses the slave view; the environment (producer,
// consumer and the external adder stage) uses the master view.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             result_cout;
  logic             busy;

  modport slave (
    input  in_valid, op_a, op_b, op_cin, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, add_cin, out_valid, result, result_cout, busy
  );

  modport master (
    output in_valid, op_a, op_b, op_cin, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, add_cin, out_valid, result, result_cout, busy
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial adder sequencer: feeds one nibble pair plus the running
// carry per cycle into an external 4-bit ripple-carry stage and collects
// the sum nibbles into a WIDTH-bit result with a final carry-out.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  nibble_serial_adder_ctrl_if.slave   bus
);
  localparam int NIBBLES = WIDTH / 4;
  // idx needs at least one bit even when there is a single nibble
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic [NIBBLES-1:0][3:0] a_q, a_d;
  logic [NIBBLES-1:0][3:0] b_q, b_d;
  logic [NIBBLES-1:0][3:0] result_q, result_d;
  logic                   result_cout_q, result_cout_d;

  // State and datapath registers; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      carry_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      result_q      <= '0;
      result_cout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      carry_q       <= carry_d;
      a_q           <= a_d;
      b_q           <= b_d;
      result_q      <= result_d;
      result_cout_q <= result_cout_d;
    end
  end

  // Next-state, datapath updates and handshake/adder-stage outputs
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    carry_d       = carry_q;
    a_d           = a_q;
    b_d           = b_q;
    result_d      = result_q;
    result_cout_d = result_cout_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    bus.add_a     = 4'd0;
    bus.add_b     = 4'd0;
    bus.add_cin   = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d      = bus.op_a;
          b_d      = bus.op_b;
          carry_d  = bus.op_cin;
          idx_d    = '0;
          result_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        bus.busy         = 1'b1;
        bus.add_a        = a_q[idx_q];
        bus.add_b        = b_q[idx_q];
        bus.add_cin      = carry_q;
        result_d[idx_q]  = bus.add_sum;
        carry_d          = bus.add_cout;
        if (idx_q == LAST_IDX) begin
          result_cout_d = bus.add_cout;
          idx_d         = '0;
          state_d       = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.result      = result_q;
  assign bus.result_cout = result_cout_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl: a WIDTH=16 instance
// driven by a vector table, hand-written corner sequences and a random
// scoreboard, plus a WIDTH=4 instance for the single-nibble case.
module tb_nibble_serial_adder_ctrl;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [15:0] last_a_seq;
  logic [3:0]  last_cin_seq;

  nibble_serial_adder_ctrl_if #(.WIDTH(16)) bus16 ();
  nibble_serial_adder_ctrl_if #(.WIDTH(4))  bus4 ();

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  nibble_serial_adder_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

  // External 4-bit ripple-carry stages
  assign {bus16.add_cout, bus16.add_sum} = 5'(bus16.add_a) + 5'(bus16.add_b) + 5'(bus16.add_cin);
  assign {bus4.add_cout, bus4.add_sum}   = 5'(bus4.add_a) + 5'(bus4.add_b) + 5'(bus4.add_cin);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic        cout;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Never accept and be busy at the same time
  always @(negedge clk) begin
    if (!rst && bus16.in_ready && bus16.busy) begin
      n_fail++;
      $display("FAIL in_ready_busy_overlap: got 1 expected 0");
    end
  end

  // One full operation on the 16-bit instance, with optional DONE stalls
  task automatic do16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic [15:0] exp_res, input logic exp_cout,
                      input int stalls, input bit hold_valid, input string tag);
    int wait_cnt;
    int lat;
    wait_cnt = 0;
    while (bus16.in_ready !== 1'b1 && wait_cnt < 20) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check({tag, "_in_ready_wait"}, 32'(bus16.in_ready), 32'd1);
    bus16.op_a     = a;
    bus16.op_b     = b;
    bus16.op_cin   = cin;
    bus16.in_valid = 1'b1;
    bus16.out_ready = 1'b0;
    @(posedge clk); #1;
    bus16.in_valid = hold_valid;
    if (hold_valid) begin
      bus16.op_a   = 16'hAAAA;
      bus16.op_b   = 16'h5555;
      bus16.op_cin = 1'b1;
    end
    last_a_seq   = '0;
    last_cin_seq = '0;
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 20) begin
      if (lat < 4) begin
        last_a_seq[4*lat +: 4] = bus16.add_a;
        last_cin_seq[lat]      = bus16.add_cin;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    for (int s = 0; s < stalls; s++) begin
      check({tag, "_stall_result"}, 32'(bus16.result), 32'(exp_res));
      check({tag, "_stall_in_ready"}, 32'(bus16.in_ready), 32'd0);
      check({tag, "_stall_out_valid"}, 32'(bus16.out_valid), 32'd1);
      @(posedge clk); #1;
    end
    check({tag, "_result"}, 32'(bus16.result), 32'(exp_res));
    check({tag, "_cout"}, 32'(bus16.result_cout), 32'(exp_cout));
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    bus16.in_valid  = 1'b0;
    check({tag, "_release"}, {29'd0, bus16.out_valid, bus16.in_ready, bus16.busy}, 32'b010);
    $display("[TB] %s: %h + %h + %0d -> %h cout %0d (lat %0d, stalls %0d)",
             tag, a, b, cin, bus16.result, bus16.result_cout, lat, stalls);
  endtask

  initial begin
    logic [16:0] sum;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    int          ovs;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.op_a = '0; bus16.op_b = '0; bus16.op_cin = 1'b0; bus16.out_ready = 1'b0;
    bus4.in_valid  = 1'b0; bus4.op_a  = '0; bus4.op_b  = '0; bus4.op_cin  = 1'b0; bus4.out_ready  = 1'b0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
    vecs[7] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_handshake", {29'd0, bus16.in_ready, bus16.out_valid, bus16.busy}, 32'b100);
    check("reset_adder_if", {23'd0, bus16.add_a, bus16.add_b, bus16.add_cin}, 32'd0);
    check("reset_result", {15'd0, bus16.result_cout, bus16.result}, 32'd0);

    // Vector table
    for (int i = 0; i < 8; i++) begin
      do16(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].cout, 0, 1'b0, $sformatf("vec%0d", i));
      if (i == 0) check("vec0_add_a_seq", 32'(last_a_seq), 32'h1234);
      if (i == 1) check("vec1_add_cin_seq", 32'(last_cin_seq), 32'b1110);
    end

    // Result held in IDLE after the handshake
    @(posedge clk); #1;
    check("idle_hold_result", {15'd0, bus16.result_cout, bus16.result}, {15'd0, 1'b0, 16'hFFFF});

    // Backpressure in DONE with in_valid held high, then a fresh op
    do16(16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 3, 1'b1, "backpressure");
    do16(16'h1000, 16'h2000, 1'b1, 16'h3001, 1'b0, 0, 1'b0, "after_bp");

    // Reset mid-RUN discards the operation
    do16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, 1'b0, "pre_abort");
    bus16.op_a = 16'h1111; bus16.op_b = 16'h2222; bus16.op_cin = 1'b0; bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_handshake", {29'd0, bus16.in_ready, bus16.out_valid, bus16.busy}, 32'b100);
    check("abort_adder_if", {23'd0, bus16.add_a, bus16.add_b, bus16.add_cin}, 32'd0);
    check("abort_result", {15'd0, bus16.result_cout, bus16.result}, 32'd0);
    ovs = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (bus16.out_valid === 1'b1) ovs++;
    end
    check("abort_no_out_valid", 32'(ovs), 32'd0);
    $display("[TB] abort: reset after 2 RUN cycles, no result produced");
    do16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0, 1'b0, "post_abort");

    // Random scoreboard with random DONE stalls
    for (int r = 0; r < 40; r++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom);
      sum = 17'(ra) + 17'(rb) + 17'(rc);
      do16(ra, rb, rc, sum[15:0], sum[16], int'($urandom_range(0, 3)), 1'($urandom), $sformatf("rand%0d", r));
    end

    // Single-nibble instance
    bus4.op_a = 4'hF; bus4.op_b = 4'h1; bus4.op_cin = 1'b1; bus4.in_valid = 1'b1;
    check("w4_in_ready", 32'(bus4.in_ready), 32'd1);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    check("w4_run_add_if", {26'd0, bus4.add_a, bus4.add_cin, bus4.out_valid}, {26'd0, 4'hF, 1'b1, 1'b0});
    @(posedge clk); #1;
    check("w4_out_valid", 32'(bus4.out_valid), 32'd1);
    check("w4_result", {27'd0, bus4.result_cout, bus4.result}, {27'd0, 1'b1, 4'h1});
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    check("w4_release", {30'd0, bus4.out_valid, bus4.in_ready}, 32'b01);
    $display("[TB] w4: f + 1 + 1 -> %h cout %0d", bus4.result, bus4.result_cout);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
